// File: rtl/bp_me_manycore_mmio_responder.sv
// Manycore -> BedRock MMIO responder: converts one remote word load/store at a time into an
// uncached 4-byte BedRock mem_fwd transaction and answers with a manycore return packet.
module bp_me_manycore_mmio_responder #(
  parameter int x_cord_width_p       = 4,
  parameter int y_cord_width_p       = 4,
  parameter int data_width_p         = 32,
  parameter int addr_width_p         = 28,
  // BlackParrot configuration widths, exposed directly instead of through a config struct
  parameter int paddr_width_p        = 32,
  parameter int bedrock_fill_width_p = 64,
  parameter int lce_id_width_p       = 4,
  parameter int did_width_p          = 3,
  localparam int mc_packet_width_lp  = addr_width_p + 4 + 4 + 5 + data_width_p
                                       + 2 * (x_cord_width_p + y_cord_width_p),
  localparam int mc_return_width_lp  = 2 + data_width_p + 5 + y_cord_width_p + x_cord_width_p,
  localparam int mem_header_width_lp = did_width_p + lce_id_width_p + 3 + paddr_width_p + 4 + 4
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,

  input  logic [mc_packet_width_lp-1:0]   packet_i,
  input  logic                            packet_v_i,
  output logic                            packet_yumi_o,

  output logic [mc_return_width_lp-1:0]   return_packet_o,
  output logic                            return_packet_v_o,

  output logic [mem_header_width_lp-1:0]  mem_fwd_header_o,
  output logic [bedrock_fill_width_p-1:0] mem_fwd_data_o,
  output logic                            mem_fwd_v_o,
  input  logic                            mem_fwd_ready_and_i,

  input  logic [mem_header_width_lp-1:0]  mem_rev_header_i,
  input  logic [bedrock_fill_width_p-1:0] mem_rev_data_i,
  input  logic                            mem_rev_v_i,
  output logic                            mem_rev_ready_and_o,

  input  logic [paddr_width_p-1:0]        paddr_base_i,
  input  logic [lce_id_width_p-1:0]       lce_id_i,
  input  logic [did_width_p-1:0]          did_i,
  output logic                            error_o
);

  localparam int fill_words_lp = bedrock_fill_width_p / data_width_p;

  typedef enum logic [1:0] {e_ready, e_send, e_wait, e_return} state_e;

  typedef enum logic [3:0] {
    e_remote_load    = 4'd0,
    e_remote_store   = 4'd1,
    e_remote_sw      = 4'd2,
    e_remote_amoswap = 4'd3,
    e_remote_amoadd  = 4'd4,
    e_remote_amoxor  = 4'd5,
    e_remote_amoand  = 4'd6,
    e_remote_amoor   = 4'd7
  } mc_op_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } mem_msg_e;

  localparam logic [2:0] e_bedrock_msg_size_4 = 3'd2;
  localparam logic [1:0] e_return_credit      = 2'd0;
  localparam logic [1:0] e_return_int_wb      = 2'd1;

  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    logic [3:0]                op;
    logic [3:0]                mask;
    logic [4:0]                reg_id;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] src_y;
    logic [x_cord_width_p-1:0] src_x;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } mc_packet_s;

  typedef struct packed {
    logic [1:0]                pkt_type;
    logic [data_width_p-1:0]   data;
    logic [4:0]                reg_id;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } mc_return_s;

  // Fwd and rev share one header layout; payload (did, lce_id) sits in the top bits.
  typedef struct packed {
    logic [did_width_p-1:0]    did;
    logic [lce_id_width_p-1:0] lce_id;
    logic [2:0]                size;
    logic [paddr_width_p-1:0]  addr;
    logic [3:0]                subop;
    logic [3:0]                msg_type;
  } mem_header_s;

  mc_packet_s  pkt;
  mem_header_s rev_hdr;
  assign pkt     = packet_i;
  assign rev_hdr = mem_rev_header_i;

  state_e      state_q, state_d;
  logic        accept_q, accept_d;
  logic        fwd_v_q, fwd_v_d;
  logic        rev_ready_q, rev_ready_d;
  logic        ret_v_q, ret_v_d;
  logic        error_q, error_d;
  mem_header_s hdr_q, hdr_d;
  mc_return_s  ret_pkt_q, ret_pkt_d;
  logic [bedrock_fill_width_p-1:0] fwd_data_q, fwd_data_d;

  logic                     is_load, is_store_class, fwd_ok;
  logic [paddr_width_p-1:0] paddr;

  assign is_load        = (pkt.op == e_remote_load);
  assign is_store_class = (pkt.op == e_remote_store) || (pkt.op == e_remote_sw);
  assign fwd_ok         = is_load || (pkt.op == e_remote_sw)
                          || ((pkt.op == e_remote_store) && (pkt.mask == 4'hF));
  // Carry out of the add is dropped, so the physical address wraps.
  assign paddr          = paddr_base_i + paddr_width_p'({pkt.addr, 2'b00});

  // accept_q is low through reset, so a request held valid during reset is never consumed.
  assign packet_yumi_o  = packet_v_i & accept_q;

  always_comb begin
    // NOTE: every always_comb output takes its held value first; a path that skips an
    // assignment would otherwise infer a latch.
    state_d     = state_q;
    fwd_v_d     = fwd_v_q;
    rev_ready_d = rev_ready_q;
    ret_v_d     = ret_v_q;
    error_d     = error_q;
    hdr_d       = hdr_q;
    ret_pkt_d   = ret_pkt_q;
    fwd_data_d  = fwd_data_q;

    unique case (state_q)
      e_ready: begin
        if (packet_yumi_o) begin
          ret_pkt_d.pkt_type = is_store_class ? e_return_credit : e_return_int_wb;
          ret_pkt_d.data     = '0;
          ret_pkt_d.reg_id   = pkt.reg_id;
          ret_pkt_d.y_cord   = pkt.src_y;
          ret_pkt_d.x_cord   = pkt.src_x;

          hdr_d          = '0;
          hdr_d.msg_type = is_load ? e_bedrock_mem_uc_rd : e_bedrock_mem_uc_wr;
          hdr_d.addr     = paddr;
          hdr_d.size     = e_bedrock_msg_size_4;
          hdr_d.lce_id   = lce_id_i;
          hdr_d.did      = did_i;
          fwd_data_d     = is_load ? '0 : {fill_words_lp{pkt.data}};

          if (fwd_ok) begin
            state_d = e_send;
            fwd_v_d = 1'b1;
          end else begin
            state_d = e_return;
            ret_v_d = 1'b1;
            error_d = 1'b1;
          end
        end
      end

      e_send: begin
        if (mem_fwd_ready_and_i) begin
          state_d     = e_wait;
          fwd_v_d     = 1'b0;
          rev_ready_d = 1'b1;
        end
      end

      e_wait: begin
        if (rev_ready_q && mem_rev_v_i) begin
          state_d     = e_return;
          rev_ready_d = 1'b0;
          ret_v_d     = 1'b1;
          if (ret_pkt_q.pkt_type == e_return_int_wb) begin
            ret_pkt_d.data = mem_rev_data_i[data_width_p-1:0];
          end
          if (rev_hdr.msg_type != hdr_q.msg_type) begin
            error_d = 1'b1;
          end
        end
      end

      e_return: begin
        state_d = e_ready;
        ret_v_d = 1'b0;
      end

      default: state_d = e_ready;
    endcase

    accept_d = (state_d == e_ready);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_ready;
      accept_q    <= 1'b0;
      fwd_v_q     <= 1'b0;
      rev_ready_q <= 1'b0;
      ret_v_q     <= 1'b0;
      error_q     <= 1'b0;
      hdr_q       <= '0;
      ret_pkt_q   <= '0;
      fwd_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      accept_q    <= accept_d;
      fwd_v_q     <= fwd_v_d;
      rev_ready_q <= rev_ready_d;
      ret_v_q     <= ret_v_d;
      error_q     <= error_d;
      hdr_q       <= hdr_d;
      ret_pkt_q   <= ret_pkt_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign mem_fwd_v_o         = fwd_v_q;
  assign mem_fwd_header_o    = hdr_q;
  assign mem_fwd_data_o      = fwd_data_q;
  assign mem_rev_ready_and_o = rev_ready_q;
  assign return_packet_v_o   = ret_v_q;
  assign return_packet_o     = ret_pkt_q;
  assign error_o             = error_q;

  // Destination coordinates were consumed by the network; rev fields besides msg_type are ignored.
  logic unused_bits;
  assign unused_bits = ^{pkt.y_cord, pkt.x_cord,
                         mem_rev_data_i[bedrock_fill_width_p-1:data_width_p],
                         rev_hdr.did, rev_hdr.lce_id, rev_hdr.size, rev_hdr.addr, rev_hdr.subop};

endmodule

// File: tb/tb_bp_me_manycore_mmio_responder.sv
// Scoreboard bench for bp_me_manycore_mmio_responder: directed requests push expected fwd and
// return packets; a negedge monitor pops and compares whenever the DUT presents them.
module tb_bp_me_manycore_mmio_responder;

  localparam int XW = 4, YW = 4, DW = 32, AW = 28, PW = 32, FW = 64, LW = 4, DIDW = 3;
  localparam int PKT_W = AW + 4 + 4 + 5 + DW + 2 * (XW + YW);
  localparam int RET_W = 2 + DW + 5 + YW + XW;
  localparam int HDR_W = DIDW + LW + 3 + PW + 4 + 4;

  localparam logic [3:0] OP_LOAD = 4'd0, OP_STORE = 4'd1, OP_SW = 4'd2, OP_AMOADD = 4'd4;
  localparam logic [3:0] UC_RD = 4'd2, UC_WR = 4'd3;
  localparam logic [1:0] CREDIT = 2'd0, INT_WB = 2'd1;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic [PKT_W-1:0] packet_i;
  logic             packet_v_i;
  logic             packet_yumi_o;
  logic [RET_W-1:0] return_packet_o;
  logic             return_packet_v_o;
  logic [HDR_W-1:0] mem_fwd_header_o;
  logic [FW-1:0]    mem_fwd_data_o;
  logic             mem_fwd_v_o;
  logic             mem_fwd_ready_and_i;
  logic [HDR_W-1:0] mem_rev_header_i;
  logic [FW-1:0]    mem_rev_data_i;
  logic             mem_rev_v_i;
  logic             mem_rev_ready_and_o;
  logic [PW-1:0]    paddr_base_i;
  logic [LW-1:0]    lce_id_i;
  logic [DIDW-1:0]  did_i;
  logic             error_o;

  bp_me_manycore_mmio_responder #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW), .addr_width_p(AW),
    .paddr_width_p(PW), .bedrock_fill_width_p(FW), .lce_id_width_p(LW), .did_width_p(DIDW)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .packet_i(packet_i), .packet_v_i(packet_v_i), .packet_yumi_o(packet_yumi_o),
    .return_packet_o(return_packet_o), .return_packet_v_o(return_packet_v_o),
    .mem_fwd_header_o(mem_fwd_header_o), .mem_fwd_data_o(mem_fwd_data_o),
    .mem_fwd_v_o(mem_fwd_v_o), .mem_fwd_ready_and_i(mem_fwd_ready_and_i),
    .mem_rev_header_i(mem_rev_header_i), .mem_rev_data_i(mem_rev_data_i),
    .mem_rev_v_i(mem_rev_v_i), .mem_rev_ready_and_o(mem_rev_ready_and_o),
    .paddr_base_i(paddr_base_i), .lce_id_i(lce_id_i), .did_i(did_i), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk_pkt(input logic [AW-1:0] addr, input logic [3:0] op,
      input logic [3:0] mask, input logic [4:0] reg_id, input logic [31:0] data,
      input logic [3:0] src_y, input logic [3:0] src_x);
    return {addr, op, mask, reg_id, data, src_y, src_x, 4'h0, 4'h0};
  endfunction

  // Expected fwd header: did=5, lce_id=9, size_4 (code 2), subop 0.
  function automatic logic [HDR_W-1:0] mk_hdr(input logic [3:0] t, input logic [31:0] paddr);
    return {3'h5, 4'h9, 3'd2, paddr, 4'h0, t};
  endfunction

  function automatic logic [HDR_W-1:0] mk_rev(input logic [3:0] t);
    return {3'h0, 4'h0, 3'd2, 32'h0, 4'h0, t};
  endfunction

  function automatic logic [RET_W-1:0] mk_ret(input logic [1:0] t, input logic [31:0] data,
      input logic [4:0] reg_id, input logic [3:0] y, input logic [3:0] x);
    return {t, data, reg_id, y, x};
  endfunction

  logic [HDR_W+FW-1:0] fwd_q[$];
  logic [RET_W-1:0]    ret_q[$];

  // Monitor / scoreboard
  int cyc = 0, yumi_cyc = 0, ret_cyc = 0, fwd_count = 0;
  bit busy = 0, prev_fwd_v = 0, prev_fwd_hs = 0, prev_ret_v = 0;
  logic [HDR_W-1:0]    prev_hdr;
  logic [FW-1:0]       prev_data;
  logic [HDR_W+FW-1:0] fwd_exp;

  always @(negedge clk_i) begin
    cyc++;
    if (!reset_n_i) begin
      busy = 0; prev_fwd_v = 0; prev_fwd_hs = 0; prev_ret_v = 0;
    end else begin
      if (packet_yumi_o) begin
        check("yumi_while_busy", busy, 0);
        busy = 1;
        yumi_cyc = cyc;
      end
      if (mem_fwd_v_o && prev_fwd_v && !prev_fwd_hs) begin
        check("fwd_hdr_stable", mem_fwd_header_o, prev_hdr);
        check("fwd_data_stable", mem_fwd_data_o, prev_data);
      end
      if (mem_fwd_v_o && mem_fwd_ready_and_i) begin
        fwd_count++;
        if (fwd_q.size() == 0) check("unexpected_fwd", mem_fwd_v_o, 0);
        else begin
          fwd_exp = fwd_q.pop_front();
          check("fwd_hdr", mem_fwd_header_o, fwd_exp[HDR_W+FW-1:FW]);
          check("fwd_data", mem_fwd_data_o, fwd_exp[FW-1:0]);
        end
      end
      if (return_packet_v_o) begin
        check("ret_one_cycle", prev_ret_v, 0);
        if (ret_q.size() == 0) check("unexpected_ret", return_packet_v_o, 0);
        else check("ret_pkt", return_packet_o, ret_q.pop_front());
        busy = 0;
        ret_cyc = cyc;
      end
      prev_fwd_v  = mem_fwd_v_o;
      prev_fwd_hs = mem_fwd_v_o & mem_fwd_ready_and_i;
      prev_hdr    = mem_fwd_header_o;
      prev_data   = mem_fwd_data_o;
      prev_ret_v  = return_packet_v_o;
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic [PKT_W-1:0] p);
    packet_i   = p;
    packet_v_i = 1'b1;
  endtask

  task automatic wait_yumi(input string name);
    int n = 0;
    while (1) begin
      @(negedge clk_i);
      if (packet_yumi_o) break;
      n++;
      if (n > 40) begin
        check(name, packet_yumi_o, 1);
        packet_v_i = 1'b0;
        return;
      end
    end
    @(posedge clk_i); #1;
    packet_v_i = 1'b0;
  endtask

  // Memory side: optional fwd stall, rev raised together with fwd ready (before e_wait).
  task automatic mem_txn(input int stall, input logic [3:0] rtype, input logic [63:0] rdata,
                         input bit give_rev);
    int n = 0;
    mem_rev_header_i = mk_rev(rtype);
    mem_rev_data_i   = rdata;
    if (stall == 0) begin
      mem_fwd_ready_and_i = 1'b1;
      mem_rev_v_i         = give_rev;
    end
    while (1) begin
      @(negedge clk_i);
      if (mem_fwd_v_o) break;
      n++;
      if (n > 40) begin
        check("fwd_timeout", mem_fwd_v_o, 1);
        mem_fwd_ready_and_i = 1'b0;
        mem_rev_v_i         = 1'b0;
        return;
      end
    end
    if (stall > 0) begin
      repeat (stall) @(posedge clk_i);
      #1;
      mem_fwd_ready_and_i = 1'b1;
      mem_rev_v_i         = give_rev;
      @(negedge clk_i);
    end
    check("rev_ready_in_send", mem_rev_ready_and_o, 0);
    @(posedge clk_i); #1;
    mem_fwd_ready_and_i = 1'b0;
    if (give_rev) begin
      n = 0;
      while (1) begin
        @(negedge clk_i);
        if (mem_rev_ready_and_o) break;
        n++;
        if (n > 40) begin
          check("rev_timeout", mem_rev_ready_and_o, 1);
          break;
        end
      end
      @(posedge clk_i); #1;
      mem_rev_v_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    reset_n_i = 1'b0;
    packet_v_i = 1'b0; mem_fwd_ready_and_i = 1'b0; mem_rev_v_i = 1'b0;
    settle(2);
    reset_n_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  int fwd_before;

  initial begin
    reset_n_i = 1'b0;
    packet_i = mk_pkt(28'h100, OP_LOAD, 4'h0, 5'd5, 32'h0, 4'd3, 4'd2);
    packet_v_i = 1'b1;
    mem_fwd_ready_and_i = 1'b0; mem_rev_v_i = 1'b0;
    mem_rev_header_i = '0; mem_rev_data_i = '0;
    paddr_base_i = 32'h8000_0000; lce_id_i = 4'h9; did_i = 3'h5;

    // Reset with a request pending: nothing consumed, all outputs quiet
    repeat (3) @(negedge clk_i);
    check("rst_yumi", packet_yumi_o, 0);
    check("rst_fwd_v", mem_fwd_v_o, 0);
    check("rst_rev_ready", mem_rev_ready_and_o, 0);
    check("rst_ret_v", return_packet_v_o, 0);
    check("rst_error", error_o, 0);
    @(posedge clk_i); #1;
    packet_v_i = 1'b0;
    reset_n_i  = 1'b1;
    settle(2);

    // Load 0x100 from src (x=2,y=3) -> uc_rd 0x8000_0400, int_wb 0xDEADBEEF
    fwd_q.push_back({mk_hdr(UC_RD, 32'h8000_0400), 64'h0});
    ret_q.push_back(mk_ret(INT_WB, 32'hDEAD_BEEF, 5'd5, 4'd3, 4'd2));
    drive_req(mk_pkt(28'h100, OP_LOAD, 4'h0, 5'd5, 32'h0, 4'd3, 4'd2));
    wait_yumi("yumi_load");
    mem_txn(0, UC_RD, 64'h1111_2222_DEAD_BEEF, 1);
    settle(2);
    check("load_latency", ret_cyc - yumi_cyc, 3);
    check("load_error", error_o, 0);

    // sw with 4-cycle fwd stall, second store (mask F) held valid behind it
    fwd_q.push_back({mk_hdr(UC_WR, 32'h8000_0100), 64'h1234_5678_1234_5678});
    ret_q.push_back(mk_ret(CREDIT, 32'h0, 5'd7, 4'd1, 4'd1));
    fwd_q.push_back({mk_hdr(UC_WR, 32'h8000_0110), 64'hA5A5_0F0F_A5A5_0F0F});
    ret_q.push_back(mk_ret(CREDIT, 32'h0, 5'd3, 4'd6, 4'd5));
    drive_req(mk_pkt(28'h40, OP_SW, 4'h0, 5'd7, 32'h1234_5678, 4'd1, 4'd1));
    wait_yumi("yumi_sw");
    drive_req(mk_pkt(28'h44, OP_STORE, 4'hF, 5'd3, 32'hA5A5_0F0F, 4'd6, 4'd5));
    mem_txn(4, UC_WR, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    wait_yumi("yumi_store2");
    check("store2_yumi_after_ret", yumi_cyc - ret_cyc, 1);
    mem_txn(0, UC_WR, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    settle(2);
    check("store_error", error_o, 0);

    // Address wrap: 0xFFFF_FFF0 + (0x8 << 2) -> 0x0000_0010
    paddr_base_i = 32'hFFFF_FFF0;
    fwd_q.push_back({mk_hdr(UC_RD, 32'h0000_0010), 64'h0});
    ret_q.push_back(mk_ret(INT_WB, 32'h0BAD_F00D, 5'd1, 4'd0, 4'd7));
    drive_req(mk_pkt(28'h8, OP_LOAD, 4'h0, 5'd1, 32'h0, 4'd0, 4'd7));
    wait_yumi("yumi_wrap");
    mem_txn(0, UC_RD, 64'h0000_0000_0BAD_F00D, 1);
    settle(2);
    paddr_base_i = 32'h8000_0000;

    // Rev msg_type mismatch: still completes with rev data, error set
    fwd_q.push_back({mk_hdr(UC_RD, 32'h8000_0020), 64'h0});
    ret_q.push_back(mk_ret(INT_WB, 32'hCAFE_F00D, 5'd9, 4'd2, 4'd4));
    drive_req(mk_pkt(28'h8, OP_LOAD, 4'h0, 5'd9, 32'h0, 4'd2, 4'd4));
    wait_yumi("yumi_mismatch");
    mem_txn(0, UC_WR, 64'h0000_0000_CAFE_F00D, 1);
    settle(2);
    check("mismatch_error", error_o, 1);

    do_reset();
    check("error_cleared", error_o, 0);
    settle(1);

    // Partial-mask store and AMO add: no fwd, error sticky, data 0
    fwd_before = fwd_count;
    ret_q.push_back(mk_ret(CREDIT, 32'h0, 5'd2, 4'd1, 4'd3));
    drive_req(mk_pkt(28'h10, OP_STORE, 4'h3, 5'd2, 32'h5555_AAAA, 4'd1, 4'd3));
    wait_yumi("yumi_partial");
    settle(2);
    check("partial_error", error_o, 1);
    ret_q.push_back(mk_ret(INT_WB, 32'h0, 5'd4, 4'd2, 4'd2));
    drive_req(mk_pkt(28'h10, OP_AMOADD, 4'h0, 5'd4, 32'h0000_0001, 4'd2, 4'd2));
    wait_yumi("yumi_amo");
    settle(6);
    check("amo_error_sticky", error_o, 1);
    check("no_fwd_for_unsupported", fwd_count - fwd_before, 0);

    // Reset during e_wait abandons the transaction
    fwd_q.push_back({mk_hdr(UC_RD, 32'h8000_0080), 64'h0});
    drive_req(mk_pkt(28'h20, OP_LOAD, 4'h0, 5'd6, 32'h0, 4'd1, 4'd1));
    wait_yumi("yumi_abandon");
    mem_txn(0, UC_RD, 64'h0, 0);
    @(negedge clk_i);
    check("rev_ready_in_wait", mem_rev_ready_and_o, 1);
    @(posedge clk_i); #1;
    reset_n_i = 1'b0;
    #1;
    check("midwait_rst_rev_ready", mem_rev_ready_and_o, 0);
    check("midwait_rst_ret_v", return_packet_v_o, 0);
    settle(2);
    reset_n_i = 1'b1;
    settle(1);

    fwd_q.push_back({mk_hdr(UC_WR, 32'h8000_0004), 64'h0F0F_F0F0_0F0F_F0F0});
    ret_q.push_back(mk_ret(CREDIT, 32'h0, 5'd8, 4'd0, 4'd1));
    drive_req(mk_pkt(28'h1, OP_SW, 4'h0, 5'd8, 32'h0F0F_F0F0, 4'd0, 4'd1));
    wait_yumi("yumi_after_rst");
    mem_txn(0, UC_WR, 64'h0, 1);
    settle(3);
    check("post_rst_error", error_o, 0);

    check("fwd_q_drained", fwd_q.size(), 0);
    check("ret_q_drained", ret_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
